// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-register fields in, hold/bubble/flush/forward controls out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic [4:0]       exmem_rd;
    logic             exmem_reg_write;
    logic [4:0]       memwb_rd;
    logic             memwb_reg_write;
    logic             branch_taken;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, exmem_rd, exmem_reg_write,
               memwb_rd, memwb_reg_write, branch_taken,
        input  pc_hold, ifid_hold, idex_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, exmem_rd, exmem_reg_write,
               memwb_rd, memwb_reg_write, branch_taken,
        output pc_hold, ifid_hold, idex_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall FSM, branch flush, ALU forwarding selects
// and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input logic                clk,
    input logic                rst_n,
    pipe_hazard_ctrl_if.slave  io_hz
);
    // Down-counter holds the bubbles still owed after the first one (LOAD_STALL_CYCLES-2 max).
    localparam int unsigned    DCW      = (LOAD_STALL_CYCLES > 2) ?
                                          $clog2(LOAD_STALL_CYCLES - 1) : 1;
    localparam logic [DCW-1:0] CNT_INIT = DCW'((LOAD_STALL_CYCLES > 1) ?
                                               (LOAD_STALL_CYCLES - 2) : 0);

    typedef enum logic {StRun, StStall} state_e;

    state_e           r_state_q;
    state_e           w_state_d;
    logic [DCW-1:0]   r_cnt_q;
    logic [DCW-1:0]   w_cnt_d;
    logic             w_hazard;
    logic             w_stall;
    logic             w_flush;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] r_flush_cnt_q;

    assign w_hazard = io_hz.ex_mem_read && (io_hz.ex_rt != 5'd0) &&
                      ((io_hz.ex_rt == io_hz.id_rs) || (io_hz.ex_rt == io_hz.id_rt));

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_stall   = 1'b0;
        w_flush   = 1'b0;
        if (io_hz.branch_taken) begin
            // Wrong-path instructions are discarded, so any pending stall is dropped.
            w_flush   = 1'b1;
            w_state_d = StRun;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state_q)
                StRun: begin
                    if (w_hazard) begin
                        w_stall = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_state_d = StStall;
                            w_cnt_d   = CNT_INIT;
                        end
                    end
                end
                StStall: begin
                    w_stall = 1'b1;
                    if (r_cnt_q == '0) begin
                        w_state_d = StRun;
                    end else begin
                        w_cnt_d = r_cnt_q - DCW'(1);
                    end
                end
                default: w_state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= StRun;
            r_cnt_q       <= '0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            if (w_stall && (r_stall_cnt_q != '1)) begin
                r_stall_cnt_q <= r_stall_cnt_q + CNT_W'(1);
            end
            if (io_hz.branch_taken && (r_flush_cnt_q != '1)) begin
                r_flush_cnt_q <= r_flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (io_hz.exmem_reg_write && (io_hz.exmem_rd != 5'd0) && (io_hz.exmem_rd == src)) begin
            return 2'b10;
        end else if (io_hz.memwb_reg_write && (io_hz.memwb_rd != 5'd0) &&
                     (io_hz.memwb_rd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(io_hz.ex_rs);
    assign w_fwd_b = fwd_sel(io_hz.ex_rt);

    assign io_hz.pc_hold     = rst_n & w_stall;
    assign io_hz.ifid_hold   = rst_n & w_stall;
    assign io_hz.idex_bubble = rst_n & w_stall;
    assign io_hz.flush       = rst_n & w_flush;
    assign io_hz.fwd_a       = rst_n ? w_fwd_a : 2'b00;
    assign io_hz.fwd_b       = rst_n ? w_fwd_b : 2'b00;
    assign io_hz.stall_cnt   = r_stall_cnt_q;
    assign io_hz.flush_cnt   = r_flush_cnt_q;
endmodule
